cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle sequencer for the Subarashii CPU core. It steps every instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the IR, PC, register-file and memory write enables. It gates the decode outputs of the control unit so that each write happens in exactly one cycle. It also owns the shared single-port memory handshake, a memory-wait watchdog and a retired-instruction counter.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: number of cycles memReq may wait for memAck before a fault (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- opcode  in  4  opcode field of IR, valid from DECODE onward.
- memReadCtl, memWriteCtl, regWriteCtl, branchCtl, jumpCtl  in  1 each  decode outputs of the control unit.
- zero  in  1  ALU zero flag, valid in EXEC.
- memAck  in  1  memory done; read data valid / write accepted in this cycle.
- memReq  out  1  memory access request.
- memWe  out  1  1 = write access; valid while memReq=1.
- memAddrSel  out  1  0 = PC, 1 = ALU result.
- irWrite  out  1  load IR from memory read data.
- mdrWrite  out  1  load MDR from memory read data.
- regWe  out  1  register-file write enable.
- pcWrite  out  1  load PC from pcSrc mux.
- pcSrc  out  2  00 = PC+1, 01 = branch target, 10 = jump target.
- state  out  3  FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, HALT=111.
- halted  out  1  1 in HALT.
- fault  out  1  sticky; set on memory timeout.
- instret  out  16  count of retired instructions.

## Operation
- Outputs decode combinationally from the state register and the inputs. While rst=0, every output is 0 and pcSrc=00.
- On reset, state=FETCH, waitCnt=0, fault=0, instret=0. FETCH begins on the first edge with rst=1.
- FETCH: memReq=1, memAddrSel=0, memWe=0.
  - memAck=1: irWrite=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: opcode 1110 or 1111 goes to HALT (illegal; fault is not set). Any other opcode goes to EXEC.
- EXEC:
  - branchCtl=1: pcWrite=1, pcSrc=01 if zero=1 else 00, go to FETCH.
  - memReadCtl or memWriteCtl: go to MEM.
  - regWriteCtl: go to WB.
  - Otherwise: pcWrite=1, pcSrc=00, go to FETCH.
- MEM: memReq=1, memAddrSel=1, memWe=memWriteCtl. On memAck=1:
  - load: mdrWrite=1, go to WB.
  - store: pcWrite=1, pcSrc=00, go to FETCH.
- WB: regWe=1, pcWrite=1, pcSrc=10 if jumpCtl else 00, go to FETCH.
- HALT: all strobes 0. Left only by reset.
- Handshake rules:
  - memReq stays high until memAck is sampled high; memAddrSel and memWe are stable throughout.
  - memAck while memReq=0 is ignored.
  - Back-to-back accesses always have at least one cycle with memReq=0 between them.
- Watchdog:
  - waitCnt clears on entry to FETCH or MEM.
  - It increments each cycle that memReq=1 and memAck=0.
  - When waitCnt = MEM_TIMEOUT-1 and memAck=0: go to HALT, fault=1.
  - If memAck arrives in that same cycle, the ack wins and no fault is raised.
- instret increments by 1 on every cycle with pcWrite=1 and wraps FFFF→0000.
- regWe, pcWrite, irWrite and mdrWrite are each asserted for exactly one cycle per instruction, or not at all.

## Timing
- Latencies with memAck returned in the request cycle (zero-wait memory):
  - ALU op or ADI: 4 cycles (F, D, E, W).
  - LDW: 5 cycles (F, D, E, M, W).
  - STW: 4 cycles (F, D, E, M).
  - BRZ: 3 cycles (F, D, E).
  - JAL: 4 cycles (F, D, E, W).
- Each memory wait cycle adds 1 cycle to FETCH or MEM.
- The PC and IR load on the edge that ends the strobe cycle. New fetch address is valid in the following FETCH.
- rst=0 mid-instruction: outputs go to 0 in that cycle, and state is FETCH on the first edge after rst returns to 1. An outstanding request is abandoned.

## Test plan
- Zero-wait ADD (opcode 0000, regWriteCtl=1): state sequence 000,001,010,100,000. irWrite only in cycle 1, regWe and pcWrite only in cycle 4, pcSrc=00, instret 0→1.
- LDW with memAck delayed 3 cycles in MEM: memReq=1, memAddrSel=1, memWe=0 for 4 cycles. mdrWrite pulses on the ack cycle, then WB; total 8 cycles.
- BRZ: with zero=1, pcWrite=1 and pcSrc=01 in EXEC; with zero=0, pcSrc=00. Neither case asserts regWe or memReq in MEM.
- JAL (jumpCtl=1, regWriteCtl=1): in WB, regWe=1, pcWrite=1, pcSrc=10.
- Watchdog with MEM_TIMEOUT=4 and memAck held 0 in FETCH: HALT after 4 cycles, fault=1, halted=1, held until rst=0. Repeat with ack on the 4th cycle: no fault.
- Opcode 1111: HALT with fault=0. Also check reset asserted during MEM: all outputs 0, then FETCH resumes. Also preload instret to FFFF, retire one instruction, expect 0000.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Subarashii core.
// Owns the memory handshake, the memory-wait watchdog and the retired-instruction counter.
module cpu_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  opcode,
   input  logic        memReadCtl,
   input  logic        memWriteCtl,
   input  logic        regWriteCtl,
   input  logic        branchCtl,
   input  logic        jumpCtl,
   input  logic        zero,
   input  logic        memAck,
   output logic        memReq,
   output logic        memWe,
   output logic        memAddrSel,
   output logic        irWrite,
   output logic        mdrWrite,
   output logic        regWe,
   output logic        pcWrite,
   output logic [1:0]  pcSrc,
   output logic [2:0]  state,
   output logic        halted,
   output logic        fault,
   output logic [15:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'b000,
      S_DECODE = 3'b001,
      S_EXEC   = 3'b010,
      S_MEM    = 3'b011,
      S_WB     = 3'b100,
      S_HALT   = 3'b111
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt;
   logic        gap_q, gap_d;
   logic        fault_q, fault_set;
   logic [15:0] instret_q;
   logic        timeout;
   logic        req_c, we_c, addr_sel_c, ir_wr_c, mdr_wr_c, reg_we_c, pc_wr_c;
   logic [1:0]  pc_src_c;

   assign timeout = (wait_cnt == 8'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      fault_set  = 1'b0;
      req_c      = 1'b0;
      we_c       = 1'b0;
      addr_sel_c = 1'b0;
      ir_wr_c    = 1'b0;
      mdr_wr_c   = 1'b0;
      reg_we_c   = 1'b0;
      pc_wr_c    = 1'b0;
      pc_src_c   = 2'b00;
      case (state_q)
         S_FETCH: begin
            // A store ack leads straight here; hold memReq low one cycle so accesses never abut.
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               req_c = 1'b1;
               if (memAck) begin
                  ir_wr_c = 1'b1;
                  state_d = S_DECODE;
               end else if (timeout) begin
                  fault_set = 1'b1;
                  state_d   = S_HALT;
               end
            end
         end
         S_DECODE: begin
            if (opcode == 4'hE || opcode == 4'hF) state_d = S_HALT;
            else                                  state_d = S_EXEC;
         end
         S_EXEC: begin
            if (branchCtl) begin
               pc_wr_c  = 1'b1;
               pc_src_c = zero ? 2'b01 : 2'b00;
               state_d  = S_FETCH;
            end else if (memReadCtl || memWriteCtl) begin
               state_d = S_MEM;
            end else if (regWriteCtl) begin
               state_d = S_WB;
            end else begin
               pc_wr_c = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            req_c      = 1'b1;
            addr_sel_c = 1'b1;
            we_c       = memWriteCtl;
            if (memAck) begin
               if (memWriteCtl) begin
                  pc_wr_c = 1'b1;
                  gap_d   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_wr_c = 1'b1;
                  state_d  = S_WB;
               end
            end else if (timeout) begin
               fault_set = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            reg_we_c = 1'b1;
            pc_wr_c  = 1'b1;
            pc_src_c = jumpCtl ? 2'b10 : 2'b00;
            state_d  = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   // Everything visible is forced to zero while reset is held, independent of the registers.
   always_comb begin
      memReq     = rst & req_c;
      memWe      = rst & we_c;
      memAddrSel = rst & addr_sel_c;
      irWrite    = rst & ir_wr_c;
      mdrWrite   = rst & mdr_wr_c;
      regWe      = rst & reg_we_c;
      pcWrite    = rst & pc_wr_c;
      pcSrc      = rst ? pc_src_c : 2'b00;
      state      = rst ? state_q : 3'b000;
      halted     = rst && (state_q == S_HALT);
      fault      = rst & fault_q;
      instret    = rst ? instret_q : 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         gap_q     <= 1'b0;
         wait_cnt  <= 8'd0;
         fault_q   <= 1'b0;
         instret_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         if (fault_set) fault_q <= 1'b1;
         if (pc_wr_c) instret_q <= instret_q + 16'd1;
         if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
            wait_cnt <= 8'd0;
         else if (req_c && !memAck)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle output vectors for each instruction class,
// watchdog, halt, reset and counter wrap.
module tb_cpu_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  opcode;
   logic        memReadCtl, memWriteCtl, regWriteCtl, branchCtl, jumpCtl, zero, memAck;
   logic        memReq, memWe, memAddrSel, irWrite, mdrWrite, regWe, pcWrite;
   logic [1:0]  pcSrc;
   logic [2:0]  state;
   logic        halted, fault;
   logic [15:0] instret;
   int          checks = 0;
   int          errors = 0;

   // {memReq,memWe,memAddrSel,irWrite,mdrWrite,regWe,pcWrite}_{pcSrc}_{state}_{halted,fault}
   wire [13:0] obs = {memReq, memWe, memAddrSel, irWrite, mdrWrite, regWe, pcWrite,
                      pcSrc, state, halted, fault};

   always #5 clk = ~clk;

   cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode),
      .memReadCtl(memReadCtl), .memWriteCtl(memWriteCtl), .regWriteCtl(regWriteCtl),
      .branchCtl(branchCtl), .jumpCtl(jumpCtl), .zero(zero), .memAck(memAck),
      .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel), .irWrite(irWrite),
      .mdrWrite(mdrWrite), .regWe(regWe), .pcWrite(pcWrite), .pcSrc(pcSrc),
      .state(state), .halted(halted), .fault(fault), .instret(instret)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0; opcode = 4'h0; memReadCtl = 1'b0; memWriteCtl = 1'b0; regWriteCtl = 1'b0;
      branchCtl = 1'b0; jumpCtl = 1'b0; zero = 1'b0; memAck = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; memAck = 1'b1; memReadCtl = 1'b1; regWriteCtl = 1'b1; opcode = 4'h0;
      step(); step(); #1;
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL reset_outputs obs=%b want=%b", obs, 14'd0); end
      checks++;
      if (instret !== 16'h0000) begin errors++; $display("FAIL reset_instret got=%h want=0000", instret); end
      rst = 1'b1; #1;
      checks++;
      if (obs !== 14'b1001000_00_000_00) begin
         errors++; $display("FAIL reset_first_fetch obs=%b want=%b", obs, 14'b1001000_00_000_00);
      end
   endtask

   task automatic test_add();
      bit         ack[5] = '{1, 1, 1, 1, 1};
      logic [13:0] ev[5] = '{14'b1001000_00_000_00, 14'b0000000_00_001_00, 14'b0000000_00_010_00,
                             14'b0000011_00_100_00, 14'b1001000_00_000_00};
      do_reset();
      opcode = 4'h0; regWriteCtl = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         memAck = ack[i]; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL add_c%0d obs=%b want=%b", i + 1, obs, ev[i]); end
      end
      checks++;
      if (instret !== 16'd1) begin errors++; $display("FAIL add_instret got=%h want=0001", instret); end
   endtask

   task automatic test_ldw_wait();
      bit         ack[9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
      logic [13:0] ev[9] = '{14'b1001000_00_000_00, 14'b0000000_00_001_00, 14'b0000000_00_010_00,
                             14'b1010000_00_011_00, 14'b1010000_00_011_00, 14'b1010000_00_011_00,
                             14'b1010100_00_011_00, 14'b0000011_00_100_00, 14'b1000000_00_000_00};
      do_reset();
      opcode = 4'h8; memReadCtl = 1'b1; regWriteCtl = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) step();
         memAck = ack[i]; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL ldw_c%0d obs=%b want=%b", i + 1, obs, ev[i]); end
      end
      checks++;
      if (instret !== 16'd1) begin errors++; $display("FAIL ldw_instret got=%h want=0001", instret); end
   endtask

   task automatic test_stw_back_to_back();
      bit         ack[6] = '{1, 0, 0, 1, 1, 1};
      logic [13:0] ev[6] = '{14'b1001000_00_000_00, 14'b0000000_00_001_00, 14'b0000000_00_010_00,
                             14'b1110001_00_011_00, 14'b0000000_00_000_00, 14'b1001000_00_000_00};
      do_reset();
      opcode = 4'h9; memWriteCtl = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         memAck = ack[i]; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL stw_c%0d obs=%b want=%b", i + 1, obs, ev[i]); end
      end
   endtask

   task automatic test_brz(input logic z);
      bit         ack[4] = '{1, 0, 0, 0};
      logic [13:0] ev[4] = '{14'b1001000_00_000_00, 14'b0000000_00_001_00, 14'b0000001_00_010_00,
                             14'b1000000_00_000_00};
      if (z) ev[2] = 14'b0000001_01_010_00;
      do_reset();
      opcode = 4'hA; branchCtl = 1'b1; zero = z;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         memAck = ack[i]; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL brz_z%0d_c%0d obs=%b want=%b", z, i + 1, obs, ev[i]); end
      end
      checks++;
      if (instret !== 16'd1) begin errors++; $display("FAIL brz_z%0d_instret got=%h want=0001", z, instret); end
   endtask

   task automatic test_jal();
      bit         ack[5] = '{1, 0, 0, 0, 0};
      logic [13:0] ev[5] = '{14'b1001000_00_000_00, 14'b0000000_00_001_00, 14'b0000000_00_010_00,
                             14'b0000011_10_100_00, 14'b1000000_00_000_00};
      do_reset();
      opcode = 4'hC; jumpCtl = 1'b1; regWriteCtl = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         memAck = ack[i]; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL jal_c%0d obs=%b want=%b", i + 1, obs, ev[i]); end
      end
   endtask

   task automatic test_watchdog();
      bit         rv[8]  = '{1, 1, 1, 1, 1, 1, 0, 1};
      logic [13:0] ev[8] = '{14'b1000000_00_000_00, 14'b1000000_00_000_00, 14'b1000000_00_000_00,
                             14'b1000000_00_000_00, 14'b0000000_00_111_11, 14'b0000000_00_111_11,
                             14'b0000000_00_000_00, 14'b1000000_00_000_00};
      logic [13:0] ew[5] = '{14'b1000000_00_000_00, 14'b1000000_00_000_00, 14'b1000000_00_000_00,
                             14'b1001000_00_000_00, 14'b0000000_00_001_00};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step();
         memAck = 1'b0; rst = rv[i]; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL wdog_c%0d obs=%b want=%b", i + 1, obs, ev[i]); end
      end
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         memAck = (i == 3); #1;
         checks++;
         if (obs !== ew[i]) begin errors++; $display("FAIL wdog_ack_c%0d obs=%b want=%b", i + 1, obs, ew[i]); end
      end
   endtask

   task automatic test_illegal_halt();
      logic [13:0] ev[4] = '{14'b1001000_00_000_00, 14'b0000000_00_001_00, 14'b0000000_00_111_10,
                             14'b0000000_00_111_10};
      do_reset();
      opcode = 4'hF; regWriteCtl = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         memAck = 1'b1; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL halt_c%0d obs=%b want=%b", i + 1, obs, ev[i]); end
      end
   endtask

   task automatic test_reset_in_mem();
      bit         ack[6] = '{1, 0, 0, 0, 0, 0};
      bit         rv[6]  = '{1, 1, 1, 1, 0, 1};
      logic [13:0] ev[6] = '{14'b1001000_00_000_00, 14'b0000000_00_001_00, 14'b0000000_00_010_00,
                             14'b1010000_00_011_00, 14'b0000000_00_000_00, 14'b1000000_00_000_00};
      do_reset();
      opcode = 4'h8; memReadCtl = 1'b1; regWriteCtl = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         memAck = ack[i]; rst = rv[i]; #1;
         checks++;
         if (obs !== ev[i]) begin errors++; $display("FAIL rstmem_c%0d obs=%b want=%b", i + 1, obs, ev[i]); end
      end
   endtask

   task automatic test_instret_wrap();
      do_reset();
      opcode = 4'hA; branchCtl = 1'b1; zero = 1'b0; memAck = 1'b1;
      force dut.instret_q = 16'hFFFF;
      #1;
      release dut.instret_q;
      #1;
      checks++;
      if (instret !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h want=ffff", instret); end
      step(); memAck = 1'b0; step(); step(); #1;
      checks++;
      if (instret !== 16'h0000) begin errors++; $display("FAIL wrap_instret got=%h want=0000", instret); end
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout time=%0t limit=100000", $time);
      $fatal(1);
   end

   initial begin
      do_reset();
      test_reset();
      test_add();
      test_ldw_wait();
      test_stw_back_to_back();
      test_brz(1'b1);
      test_brz(1'b0);
      test_jal();
      test_watchdog();
      test_illegal_halt();
      test_reset_in_mem();
      test_instret_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
